// File: rtl/clock_domain_pkg.sv
// Shared definitions for the clock-domain handshake blocks (import and export sides).
package clock_domain_pkg;

   // Handshake state; one bit, both encodings are legal states.
   typedef enum logic {
      WAIT_VALID   = 1'b0,
      WAIT_RELEASE = 1'b1
   } hs_state_e;

   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 4;

   // Keeps a synchronizer depth inside the supported range so that an
   // out-of-range parameter still yields a working (if re-timed) chain.
   function automatic int unsigned clamp_sync_stages(input int unsigned n);
      if (n < SYNC_STAGES_MIN) begin
         return SYNC_STAGES_MIN;
      end
      if (n > SYNC_STAGES_MAX) begin
         return SYNC_STAGES_MAX;
      end
      return n;
   endfunction

endpackage

// File: rtl/clock_domain_sync.sv
// Generic 1-bit multi-flop synchronizer, async reset to 0.
module clock_domain_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the asynchronous input one stage further down the chain each edge.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_domain_import.sv
// Destination side of the 4-phase valid/ack clock-domain handshake.
// A captured word is held in a one-entry buffer presented as a valid/ready
// stream; while the buffer is occupied the ack is withheld, which stalls the
// source instead of dropping words.
//
//   state        | meaning
//   WAIT_VALID   | idle; capture on synchronized valid when the buffer is free
//   WAIT_RELEASE | word captured, ack high; wait for source valid to drop
module clock_domain_import
   import clock_domain_pkg::*;
#(
   parameter int unsigned SIZE        = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [SIZE-1:0] data,
   output logic            valid,
   input  logic            ready,
   input  logic [SIZE-1:0] handshake_data,
   input  logic            handshake_valid,
   output logic            handshake_ack
);

   localparam int unsigned STAGES = clamp_sync_stages(SYNC_STAGES);

   logic            valid_s;
   logic            pop;
   logic            buf_free;

   hs_state_e       state_q;
   hs_state_e       state_d;
   logic            ack_q;
   logic            ack_d;
   logic            full_q;
   logic            full_d;
   logic [SIZE-1:0] data_q;
   logic [SIZE-1:0] data_d;

   clock_domain_sync #(
      .STAGES (STAGES)
   ) u_valid_sync (
      .clk (clk),
      .rst (rst),
      .d   (handshake_valid),
      .q   (valid_s)
   );

   // Next-state, buffer and ack logic; a pop and a capture may share one edge.
   always_comb begin
      pop      = full_q && ready;
      buf_free = !full_q || pop;

      state_d  = state_q;
      ack_d    = ack_q;
      full_d   = full_q && !pop;
      data_d   = data_q;

      unique case (state_q)
         WAIT_VALID: begin
            // handshake_data has been stable for the whole synchronizer delay
            // by the time valid_s is seen high, so it is sampled directly.
            if (valid_s && buf_free) begin
               data_d  = handshake_data;
               full_d  = 1'b1;
               ack_d   = 1'b1;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!valid_s) begin
               ack_d   = 1'b0;
               state_d = WAIT_VALID;
            end
         end
         default: begin
            state_d = WAIT_VALID;
            ack_d   = 1'b0;
         end
      endcase
   end

   // Handshake FSM with registered ack, buffer flag and data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_VALID;
         ack_q   <= 1'b0;
         full_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         full_q  <= full_d;
         data_q  <= data_d;
      end
   end

   assign data          = data_q;
   assign valid         = full_q;
   assign handshake_ack = ack_q;

endmodule

// File: tb/tb_clock_domain_import.sv
// Scoreboarded bench for clock_domain_import: stimulus pushes expected words,
// a negedge monitor pops and compares whenever the DUT hands a word over.
module tb_clock_domain_import;

   logic       clk = 1'b0;
   logic       clk_src = 1'b0;
   logic       rst = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] hs_data = 8'h00;
   logic       hs_valid = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       ack;

   logic       lat_ready = 1'b1;
   logic [7:0] lat_data = 8'h00;
   logic       lat_valid = 1'b0;
   logic [7:0] data3;
   logic [7:0] data4;
   logic       valid3;
   logic       valid4;
   logic       ack3;
   logic       ack4;

   int         total = 0;
   int         bad = 0;
   int         pop_cnt = 0;
   logic [7:0] exp_q[$];
   logic [2:0] hv_hist = 3'b000;
   logic       ack_prev = 1'b0;
   logic       rst_prev = 1'b1;
   bit         burst_on = 1'b0;

   // Local clock period 12, source clock period 28 (7:3), edges never coincide.
   always #6 clk = ~clk;
   initial begin
      #1;
      forever #14 clk_src = ~clk_src;
   end

   clock_domain_import #(.SIZE(8), .SYNC_STAGES(2)) dut (
      .clk (clk), .rst (rst), .data (data), .valid (valid), .ready (ready),
      .handshake_data (hs_data), .handshake_valid (hs_valid), .handshake_ack (ack)
   );

   clock_domain_import #(.SIZE(8), .SYNC_STAGES(3)) dut_s3 (
      .clk (clk), .rst (rst), .data (data3), .valid (valid3), .ready (lat_ready),
      .handshake_data (lat_data), .handshake_valid (lat_valid), .handshake_ack (ack3)
   );

   clock_domain_import #(.SIZE(8), .SYNC_STAGES(4)) dut_s4 (
      .clk (clk), .rst (rst), .data (data4), .valid (valid4), .ready (lat_ready),
      .handshake_data (lat_data), .handshake_valid (lat_valid), .handshake_ack (ack4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic v, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (ack === v) begin
            ok = 1'b1;
            break;
         end
      end
      check(nm, 32'(ok), 1);
   endtask

   task automatic drain(input string nm);
      ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      step();
      check(nm, exp_q.size(), 0);
      check({nm, "_idle"}, 32'(valid), 0);
   endtask

   // Source valid history as seen at each local edge: [2] is two edges back.
   always @(posedge clk) hv_hist <= {hv_hist[1:0], hs_valid};

   // Monitor: a word is handed over on the next edge whenever valid && ready.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %02h, expected no word", data);
         end else begin
            e = exp_q.pop_front();
            check("word", 32'(data), 32'(e));
         end
         pop_cnt++;
      end
      if (!rst && !rst_prev) begin
         if (ack && !ack_prev) check("ack_rise_needs_src_valid", 32'(hv_hist[2]), 1);
         if (!ack && ack_prev) check("ack_fall_needs_src_low", 32'(hv_hist[2]), 0);
      end
      ack_prev = ack;
      rst_prev = rst;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int k3;
      int k4;
      int p0;
      int drops;
      int tmo;

      // Reset values
      #4;
      check("rst_ack", 32'(ack), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_data", 32'(data), 0);
      check("rst_valid_s4", 32'(valid4), 0);
      step();
      step();
      rst = 1'b0;
      step();
      step();

      // Single word, SYNC_STAGES=2
      ready = 1'b1;
      p0 = pop_cnt;
      hs_data = 8'hA5;
      step();
      hs_valid = 1'b1;
      exp_q.push_back(8'hA5);
      k = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (valid) begin
            k = i;
            break;
         end
      end
      check("s2_latency", k - 1, 2);
      check("s2_data", 32'(data), 32'hA5);
      check("s2_ack_with_valid", 32'(ack), 1);
      hs_valid = 1'b0;
      k = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (!ack) begin
            k = i;
            break;
         end
      end
      check("s2_ack_fall_latency", k - 1, 2);
      repeat (3) step();
      check("s2_one_pop", pop_cnt - p0, 1);
      check("s2_idle", 32'(valid), 0);

      // Backpressure
      ready = 1'b0;
      p0 = pop_cnt;
      hs_data = 8'h11;
      step();
      hs_valid = 1'b1;
      exp_q.push_back(8'h11);
      wait_ack(1'b1, "bp_ack1_rise");
      hs_valid = 1'b0;
      wait_ack(1'b0, "bp_ack1_fall");
      check("bp_hold_valid", 32'(valid), 1);
      check("bp_hold_data", 32'(data), 32'h11);
      hs_data = 8'h22;
      step();
      hs_valid = 1'b1;
      exp_q.push_back(8'h22);
      repeat (8) step();
      check("bp_ack_blocked", 32'(ack), 0);
      check("bp_data_kept", 32'(data), 32'h11);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("bp_swap_valid", 32'(valid), 1);
      check("bp_swap_data", 32'(data), 32'h22);
      check("bp_swap_ack", 32'(ack), 1);
      hs_valid = 1'b0;
      wait_ack(1'b0, "bp_ack2_fall");
      drain("bp_drain");
      check("bp_two_pops", pop_cnt - p0, 2);

      // Held valid
      ready = 1'b1;
      p0 = pop_cnt;
      hs_data = 8'h5C;
      step();
      hs_valid = 1'b1;
      exp_q.push_back(8'h5C);
      wait_ack(1'b1, "hold_ack_rise");
      drops = 0;
      repeat (20) begin
         step();
         if (!ack) drops++;
      end
      check("hold_ack_steady", drops, 0);
      check("hold_one_word", pop_cnt - p0, 1);
      hs_valid = 1'b0;
      wait_ack(1'b0, "hold_ack_fall");
      repeat (3) step();
      check("hold_still_one", pop_cnt - p0, 1);

      // Async reset in WAIT_RELEASE with a word buffered
      ready = 1'b0;
      hs_data = 8'h3C;
      step();
      hs_valid = 1'b1;
      exp_q.push_back(8'h3C);
      wait_ack(1'b1, "rst_ack_rise");
      check("rst_buffered", 32'(valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_ack", 32'(ack), 0);
      check("rst_async_valid", 32'(valid), 0);
      check("rst_async_data", 32'(data), 0);
      exp_q.delete();
      exp_q.push_back(8'h3C);
      @(posedge clk);
      #1;
      rst = 1'b0;
      p0 = pop_cnt;
      ready = 1'b1;
      wait_ack(1'b1, "rst_recapture_ack");
      hs_valid = 1'b0;
      wait_ack(1'b0, "rst_recapture_release");
      drain("rst_drain");
      check("rst_redeliver_once", pop_cnt - p0, 1);

      // Burst of 16 random words from the 7:3 source clock, random ready
      p0 = pop_cnt;
      tmo = 0;
      burst_on = 1'b1;
      fork
         begin
            for (int w = 0; w < 16; w++) begin
               bit ok;
               @(posedge clk_src);
               hs_data = 8'($urandom);
               @(posedge clk_src);
               hs_valid = 1'b1;
               exp_q.push_back(hs_data);
               ok = 1'b0;
               for (int i = 0; i < 200; i++) begin
                  @(posedge clk_src);
                  if (ack) begin
                     ok = 1'b1;
                     break;
                  end
               end
               if (!ok) tmo++;
               hs_valid = 1'b0;
               ok = 1'b0;
               for (int i = 0; i < 200; i++) begin
                  @(posedge clk_src);
                  if (!ack) begin
                     ok = 1'b1;
                     break;
                  end
               end
               if (!ok) tmo++;
            end
            burst_on = 1'b0;
         end
         begin
            while (burst_on) begin
               @(posedge clk);
               #1;
               ready = 1'($urandom_range(0, 1));
            end
         end
      join
      check("burst_timeouts", tmo, 0);
      drain("burst_drain");
      check("burst_count", pop_cnt - p0, 16);

      // Latency for SYNC_STAGES=3 and 4
      lat_data = 8'hC3;
      step();
      lat_valid = 1'b1;
      k3 = 0;
      k4 = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (valid3 && k3 == 0) k3 = i;
         if (valid4 && k4 == 0) k4 = i;
      end
      check("s3_latency", k3 - 1, 3);
      check("s4_latency", k4 - 1, 4);
      check("s3_data", 32'(data3), 32'hC3);
      check("s4_data", 32'(data4), 32'hC3);
      check("s3_ack_held", 32'(ack3), 1);
      check("s4_ack_held", 32'(ack4), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
